nes_rom_loader: RTL and testbench

- Parametrised successor of the cartridge loader in the NES core.
- Consumes the ROM download byte stream, parses iNES 1.0 and NES 2.0 headers, and writes PRG and CHR bytes (plus the optional trainer) into SDRAM regions.
- Uses a valid/ready input handshake and a write/ack memory handshake, so SDRAM back-pressure never drops bytes.
- Produces the packed mapper_flags word consumed by the NES core, and a coded error on malformed or truncated images.

---
 rtl/nes_rom_loader.sv | 206 ++++++++++++++++++++
 tb/tb_nes_rom_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_rom_loader.sv
// nes_rom_loader: parses an iNES / NES 2.0 download stream and writes PRG, CHR and trainer bytes to SDRAM.
// Define NES_LOADER_TRAINER_EN to load a 512-byte trainer; without it trainer images are rejected with code 1.
module nes_rom_loader #(
    parameter int unsigned ADDR_W       = 22,
    parameter int unsigned PRG_BASE     = 0,
    parameter int unsigned CHR_BASE     = 32'd1 << (ADDR_W - 1),
    parameter int unsigned TRAINER_BASE = (32'd1 << ADDR_W) - 32'd512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_end,
    input  logic              invert_mirroring,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_write,
    input  logic              mem_ack,
    output logic [31:0]       mapper_flags,
    output logic              done,
    output logic              error,
    output logic [2:0]        err_code
);

    localparam int unsigned CNT_W        = ADDR_W + 1;
    localparam logic [32:0] REGION_BYTES = 33'd1 << (ADDR_W - 1);
`ifdef NES_LOADER_TRAINER_EN
    localparam bit TRAINER_EN = 1'b1;
`else
    localparam bit TRAINER_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_HEADER, S_TRAINER, S_PRG, S_CHR, S_DONE, S_ERROR} state_t;

    state_t            state_q, state_d;
    logic [3:0]        hdr_cnt_q, hdr_cnt_d;
    logic [7:0]        hdr_q [16];
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [31:0]       flags_q, flags_d, flags_new;
    logic              in_ready_d, mem_write_d, done_d, error_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [7:0]        mem_data_d;
    logic [2:0]        err_code_d;

    logic              accept, ack, last_hdr, nes20, dirty, bad_magic, exp_form;
    logic [7:0]        b15;
    logic [11:0]       prg_units, chr_units, mapper;
    logic [3:0]        submapper;
    logic [25:0]       prg_bytes;
    logic [24:0]       chr_bytes;

    function automatic logic [3:0] units_log2(input logic [11:0] units);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (units > (12'd1 << i)) r = 4'(i + 1);
        end
        return r;
    endfunction

    function automatic logic is_loading(input state_t s);
        return (s != S_DONE) && (s != S_ERROR);
    endfunction

    // Header decode; byte 15 is taken from the bus while it is being accepted
    assign accept    = in_valid && in_ready;
    assign ack       = mem_write && mem_ack;
    assign last_hdr  = (state_q == S_HEADER) && (hdr_cnt_q == 4'd15);
    assign b15       = last_hdr ? in_data : hdr_q[15];
    assign nes20     = (hdr_q[7][3:2] == 2'b10);
    assign dirty     = !nes20 && ((hdr_q[8] | hdr_q[9] | hdr_q[10] | hdr_q[11] |
                                   hdr_q[12] | hdr_q[13] | hdr_q[14] | b15) != 8'd0);
    assign bad_magic = (hdr_q[0] != 8'h4E) || (hdr_q[1] != 8'h45) ||
                       (hdr_q[2] != 8'h53) || (hdr_q[3] != 8'h1A);
    assign exp_form  = nes20 && ((hdr_q[9][3:0] == 4'hF) || (hdr_q[9][7:4] == 4'hF));
    assign prg_units = {nes20 ? hdr_q[9][3:0] : 4'd0, hdr_q[4]};
    assign chr_units = {nes20 ? hdr_q[9][7:4] : 4'd0, hdr_q[5]};
    assign prg_bytes = {prg_units, 14'd0};
    assign chr_bytes = {chr_units, 13'd0};
    assign mapper    = nes20 ? {hdr_q[8][3:0], hdr_q[7][7:4], hdr_q[6][7:4]}
                             : {4'd0, dirty ? 4'd0 : hdr_q[7][7:4], hdr_q[6][7:4]};
    assign submapper = nes20 ? hdr_q[8][7:4] : 4'd0;

    assign flags_new = {2'b00, TRAINER_EN & hdr_q[6][2], nes20, hdr_q[6][1], hdr_q[6][3],
                        chr_units == 12'd0, 1'b0, units_log2(chr_units), units_log2(prg_units),
                        submapper, mapper};

    // Mirroring bit follows the OSD override live once the image is loaded
    assign mapper_flags = flags_q | {7'd0, (state_q == S_DONE) & (hdr_q[6][0] ^ invert_mirroring), 24'd0};

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        flags_d     = flags_q;
        mem_write_d = mem_write;
        mem_addr_d  = mem_addr;
        mem_data_d  = mem_data;
        err_code_d  = err_code;

        case (state_q)
            S_HEADER: begin
                if (accept) begin
                    hdr_cnt_d = hdr_cnt_q + 4'd1;
                    if (last_hdr) begin
                        if (bad_magic) begin
                            state_d = S_ERROR; err_code_d = 3'd1;
                        end else if (exp_form) begin
                            state_d = S_ERROR; err_code_d = 3'd3;
                        end else if (prg_units == 12'd0) begin
                            state_d = S_ERROR; err_code_d = 3'd4;
                        end else if ((33'(prg_bytes) > REGION_BYTES) || (33'(chr_bytes) > REGION_BYTES)) begin
                            state_d = S_ERROR; err_code_d = 3'd2;
                        end else if (hdr_q[6][2]) begin
                            if (TRAINER_EN) begin
                                state_d = S_TRAINER;
                                ptr_d   = ADDR_W'(TRAINER_BASE);
                                rem_d   = CNT_W'(32'd512);
                            end else begin
                                state_d = S_ERROR; err_code_d = 3'd1;
                            end
                        end else begin
                            state_d = S_PRG;
                            ptr_d   = ADDR_W'(PRG_BASE);
                            rem_d   = CNT_W'(prg_bytes);
                        end
                    end
                end
            end
            S_TRAINER, S_PRG, S_CHR: begin
                if (accept) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_data_d  = in_data;
                end else if (ack) begin
                    mem_write_d = 1'b0;
                    ptr_d       = ptr_q + ADDR_W'(1);
                    rem_d       = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        if (state_q == S_TRAINER) begin
                            state_d = S_PRG;
                            ptr_d   = ADDR_W'(PRG_BASE);
                            rem_d   = CNT_W'(prg_bytes);
                        end else if ((state_q == S_PRG) && (chr_units != 12'd0)) begin
                            state_d = S_CHR;
                            ptr_d   = ADDR_W'(CHR_BASE);
                            rem_d   = CNT_W'(chr_bytes);
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: ;
        endcase

        // Truncated stream; a final acknowledge in the same cycle still completes the load
        if (in_end && is_loading(state_q) && (state_d != S_DONE)) begin
            state_d     = S_ERROR;
            err_code_d  = 3'd5;
            mem_write_d = 1'b0;
        end

        if ((state_d == S_DONE) && (state_q != S_DONE)) flags_d = flags_new;

        in_ready_d = is_loading(state_d) && !mem_write_d;
        done_d     = !is_loading(state_d);
        error_d    = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_HEADER;
            hdr_cnt_q <= 4'd0;
            ptr_q     <= ADDR_W'(PRG_BASE);
            rem_q     <= '0;
            flags_q   <= '0;
            in_ready  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= ADDR_W'(PRG_BASE);
            mem_data  <= 8'd0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= 3'd0;
            for (int i = 0; i < 16; i++) hdr_q[i] <= 8'd0;
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            flags_q   <= flags_d;
            in_ready  <= in_ready_d;
            mem_write <= mem_write_d;
            mem_addr  <= mem_addr_d;
            mem_data  <= mem_data_d;
            done      <= done_d;
            error     <= error_d;
            err_code  <= err_code_d;
            if ((state_q == S_HEADER) && accept) hdr_q[hdr_cnt_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_nes_rom_loader.sv
// Directed bench for nes_rom_loader: header decode, PRG/CHR write streams, error codes, truncation and reset.
module tb_nes_rom_loader;

    localparam int unsigned ADDR_W = 22;
    localparam logic [ADDR_W-1:0] CHR_BASE     = 22'h200000;
    localparam logic [ADDR_W-1:0] TRAINER_BASE = 22'h3FFE00;

    localparam logic [127:0] H_INES    = {32'h4E45531A, 8'h01, 8'h01, 8'h21, 8'h10, 56'h0, 8'h44};
    localparam logic [127:0] H_NES2    = {32'h4E45531A, 8'h01, 8'h00, 8'h40, 8'h08, 8'h21, 8'h00, 48'h0};
    localparam logic [127:0] H_BAD     = {32'h4F45531A, 8'h01, 8'h01, 8'h01, 8'h00, 64'h0};
    localparam logic [127:0] H_TRAINER = {32'h4E45531A, 8'h01, 8'h01, 8'h04, 8'h00, 64'h0};
    localparam logic [127:0] H_EXP     = {32'h4E45531A, 8'h01, 8'h00, 8'h00, 8'h08, 8'h00, 8'h0F, 48'h0};
    localparam logic [127:0] H_NOPRG   = {32'h4E45531A, 8'h00, 8'h01, 8'h00, 8'h00, 64'h0};
    localparam logic [127:0] H_PRGMAX  = {32'h4E45531A, 8'h80, 8'h00, 8'h00, 8'h00, 64'h0};
    localparam logic [127:0] H_PRGOVF  = {32'h4E45531A, 8'h81, 8'h00, 8'h00, 8'h00, 64'h0};
    localparam logic [127:0] H_CHROVF  = {32'h4E45531A, 8'h01, 8'h01, 8'h00, 8'h08, 8'h00, 8'h10, 48'h0};

    logic              clk = 1'b0;
    logic              reset, in_valid, in_ready, in_end, invert_mirroring;
    logic [7:0]        in_data, mem_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write, mem_ack, done, error;
    logic [31:0]       mapper_flags;
    logic [2:0]        err_code;

    int checks = 0;
    int errors = 0;
    int n_writes = 0, addr_errs = 0, data_errs = 0, wcnt = 0, sent = 0;
    int ack_delay = 0;
    bit spurious = 1'b0;
    int unsigned tr_n = 0, prg_n = 0;

    nes_rom_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_end(in_end), .invert_mirroring(invert_mirroring), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_write(mem_write), .mem_ack(mem_ack),
        .mapper_flags(mapper_flags), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int unsigned k);
        return 8'(k * 13 + (k >> 9));
    endfunction

    function automatic logic [ADDR_W-1:0] exp_addr(input int unsigned k);
        if (k < tr_n) return TRAINER_BASE + ADDR_W'(k);
        if (k - tr_n < prg_n) return ADDR_W'(k - tr_n);
        return CHR_BASE + ADDR_W'(k - tr_n - prg_n);
    endfunction

    // SDRAM model: acknowledges after ack_delay cycles and scores every acknowledged write
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else if (mem_write) begin
                if (wcnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    wcnt    = 0;
                    if (mem_addr !== exp_addr(n_writes)) addr_errs++;
                    if (mem_data !== pat(n_writes)) data_errs++;
                    n_writes++;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = spurious;
            end
        end
    end

    task automatic send(input logic [7:0] b, output bit ok);
        int t;
        t = 0;
        ok = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        while (!ok && t < 32) begin
            if (in_ready) ok = 1'b1;
            @(negedge clk);
            t++;
        end
        if (!ok) check("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic load_header(input logic [127:0] h, input int first, input int last);
        bit ok;
        ok = 1'b1;
        for (int i = first; i <= last && ok; i++) send(h[127 - 8*i -: 8], ok);
        in_valid = 1'b0;
    endtask

    task automatic stream(input int unsigned n);
        bit ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < n && ok; i++) begin
            send(pat(sent), ok);
            if (ok) sent++;
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_end    = 1'b0;
        ack_delay = 0;
        spurious  = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        n_writes = 0; addr_errs = 0; data_errs = 0; sent = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_err(input logic [127:0] h, input logic [2:0] code, input string tag);
        do_reset();
        load_header(h, 0, 15);
        check({tag, "_error"}, 32'(error), 32'd1);
        check({tag, "_code"}, 32'(err_code), 32'(code));
        check({tag, "_writes"}, 32'(n_writes), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_end = 1'b0; in_data = 8'd0; invert_mirroring = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_flags", mapper_flags, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);

        // iNES, 16 KiB PRG + 8 KiB CHR, dirty header clears mapper upper nibble
        do_reset();
        tr_n = 0; prg_n = 16384;
        load_header(H_INES, 0, 15);
        stream(24576);
        @(negedge clk);
        check("ines_done", 32'(done), 32'd1);
        check("ines_error", 32'(error), 32'd0);
        check("ines_flags", mapper_flags, 32'h0100_0002);
        check("ines_writes", 32'(n_writes), 32'd24576);
        check("ines_addr_errs", 32'(addr_errs), 32'd0);
        check("ines_data_errs", 32'(data_errs), 32'd0);
        check("ines_last_addr", 32'(mem_addr), 32'h0020_1FFF);
        check("ines_in_ready", 32'(in_ready), 32'd0);
        invert_mirroring = 1'b1;
        #1 check("ines_flags_invert", mapper_flags, 32'h0000_0002);
        invert_mirroring = 1'b0;
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check("ines_ignore_after_done", 32'(n_writes), 32'd24576);

        // Bad magic: error appears right after byte 15
        do_reset();
        load_header(H_BAD, 0, 14);
        check("magic_before_b15", 32'(error), 32'd0);
        load_header(H_BAD, 15, 15);
        check("magic_error", 32'(error), 32'd1);
        check("magic_code", 32'(err_code), 32'd1);
        check("magic_done", 32'(done), 32'd1);
        check("magic_writes", 32'(n_writes), 32'd0);

        expect_err(H_EXP, 3'd3, "exp");
        expect_err(H_NOPRG, 3'd4, "noprg");
        expect_err(H_PRGOVF, 3'd2, "prgovf");
        expect_err(H_CHROVF, 3'd2, "chrovf");

        // Exactly 2 MiB of PRG fits the region
        do_reset();
        load_header(H_PRGMAX, 0, 15);
        check("prgmax_error", 32'(error), 32'd0);
        check("prgmax_in_ready", 32'(in_ready), 32'd1);

`ifdef NES_LOADER_TRAINER_EN
        do_reset();
        tr_n = 512; prg_n = 16384;
        load_header(H_TRAINER, 0, 15);
        stream(520);
        in_end = 1'b1;
        @(negedge clk);
        in_end = 1'b0;
        check("trainer_writes", 32'(n_writes), 32'd520);
        check("trainer_addr_errs", 32'(addr_errs), 32'd0);
        check("trainer_code", 32'(err_code), 32'd5);
        tr_n = 0;
`else
        expect_err(H_TRAINER, 3'd1, "trainer");
`endif

        // Truncation with back-pressure; in_end arrives while the last write is unacknowledged
        do_reset();
        tr_n = 0; prg_n = 16384;
        load_header(H_INES, 0, 15);
        stream(950);
        ack_delay = 3; spurious = 1'b1;
        stream(50);
        in_end = 1'b1;
        @(negedge clk);
        in_end = 1'b0;
        check("trunc_error", 32'(error), 32'd1);
        check("trunc_code", 32'(err_code), 32'd5);
        check("trunc_mem_write", 32'(mem_write), 32'd0);
        check("trunc_writes", 32'(n_writes), 32'd999);
        check("trunc_addr_errs", 32'(addr_errs), 32'd0);
        check("trunc_data_errs", 32'(data_errs), 32'd0);
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check("trunc_stays_idle", 32'(mem_write), 32'd0);

        // Asynchronous reset mid-PRG, then a clean NES 2.0 load
        do_reset();
        load_header(H_NES2, 0, 15);
        stream(300);
        #2 reset = 1'b1;
        #1;
        check("areset_in_ready", 32'(in_ready), 32'd0);
        check("areset_mem_write", 32'(mem_write), 32'd0);
        check("areset_mem_addr", 32'(mem_addr), 32'd0);
        check("areset_mem_data", 32'(mem_data), 32'd0);
        check("areset_done", 32'(done), 32'd0);

        do_reset();
        tr_n = 0; prg_n = 16384;
        load_header(H_NES2, 0, 15);
        stream(16384);
        in_end = 1'b1;
        @(negedge clk);
        in_end = 1'b0;
        check("nes2_done", 32'(done), 32'd1);
        check("nes2_error", 32'(error), 32'd0);
        check("nes2_flags", mapper_flags, 32'h1200_2104);
        check("nes2_writes", 32'(n_writes), 32'd16384);
        check("nes2_addr_errs", 32'(addr_errs), 32'd0);
        check("nes2_data_errs", 32'(data_errs), 32'd0);
        check("nes2_last_addr", 32'(mem_addr), 32'h0000_3FFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
